mem_lat_model: RTL and testbench

//   Parametrised single-port memory model with programmable access latency.

---
 rtl/mem_lat_model.sv | 104 ++++++++++
 tb/tb_mem_lat_model.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_lat_model.sv
// mem_lat_model: single-port memory model with programmable latency and valid/ready channels.
// Optional random extra latency is enabled by defining MEM_RAND_LAT_EN.
module mem_lat_model #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int DEPTH = 1024,
   parameter int LATENCY = 4,
   parameter int RAND_BITS = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              stall
);
   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 2 ** RAND_BITS);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
   localparam logic [ADDR_W-1:0] OMASK = ADDR_W'(NB - 1);

   logic [1:0]        state;
   logic [CW-1:0]     cnt, lat0;
   logic              a_we, a_mis, exec;
   logic [IW-1:0]     a_idx;
   logic [DATA_W-1:0] a_wdata;
   logic [NB-1:0]     a_wstrb;
   logic [DATA_W-1:0] mem [DEPTH];

   assign exec = state == BUSY && cnt == '0;

`ifdef MEM_RAND_LAT_EN
   logic [15:0] lfsr;
   // free-running Fibonacci LFSR supplying the random extra delay
   always_ff @(posedge clk)
      lfsr <= rst ? LFSR_SEED : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign lat0 = CW'(LATENCY - 1) + CW'(lfsr[RAND_BITS-1:0]);
`else
   logic [15:0] unused_cfg;
   assign unused_cfg = LFSR_SEED + 16'(RAND_BITS);
   assign lat0 = CW'(LATENCY - 1);
`endif

   // handshake FSM: accept, count down the latency, hold the response until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         stall <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         state <= BUSY;
         cnt <= lat0;
         req_ready <= 1'b0;
         stall <= 1'b1;
      end else if (state == BUSY) begin
         cnt <= exec ? cnt : cnt - 1'b1;
         if (exec) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= a_mis;
            rsp_rdata <= (a_we || a_mis) ? '0 : mem[a_idx];
         end
      end else if (state == RESP && rsp_ready) begin
         state <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         req_ready <= 1'b1;
         stall <= 1'b0;
      end
   end

   // capture the request so inputs are free to change while busy
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         a_we <= req_we;
         a_idx <= req_addr[OW +: IW];
         a_mis <= |(req_addr & OMASK);
         a_wdata <= req_wdata;
         a_wstrb <= req_wstrb;
      end
   end

   // byte-strobed write committed only at the BUSY->RESP transition
   always_ff @(posedge clk) begin
      if (!rst && exec && a_we && !a_mis)
         for (int i = 0; i < NB; i++)
            if (a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_mem_lat_model.sv
// tb_mem_lat_model: directed self-checking bench for mem_lat_model (DATA_W=64, DEPTH=256, LATENCY=4).
module tb_mem_lat_model;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err, stall;
   logic [63:0] rsp_rdata, rd;
   logic        er;
   int          checks = 0, errors = 0, lat_last = 0;

   mem_lat_model #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .LATENCY(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // one full transaction; entered and left 1 time unit after a rising edge
   task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb, input int hold,
                       output logic [63:0] rdata, output logic err);
      int lat;
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      @(posedge clk); #1 req_valid = 1'b0;
      check("stall_busy", stall, 1);
      check("req_ready_busy", req_ready, 0);
      lat = 0;
      while (!rsp_valid && lat < 30) begin
         @(posedge clk); #1 lat++;
      end
      lat_last = lat;
`ifdef MEM_RAND_LAT_EN
      check("lat_range", lat >= 4 && lat <= 7, 1);
`else
      check("latency", lat, 4);
`endif
      rdata = rsp_rdata; err = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", rsp_valid, 1);
         check("hold_rdata", rsp_rdata, rdata);
         check("hold_stall", stall, 1);
         check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      check("idle_req_ready", req_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_stall", stall, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_stall", stall, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      // 1: full write then read
      xact(1, 64'h10, 64'h1122334455667788, 8'hFF, 0, rd, er);
      check("t1_wr_err", er, 0);
      check("t1_wr_rdata", rd, 0);
      xact(0, 64'h10, 64'h0, 8'h00, 0, rd, er);
      check("t1_rd", rd, 64'h1122334455667788);
      // 2: partial strobe
      xact(1, 64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0, rd, er);
      xact(0, 64'h10, 64'h0, 8'h00, 0, rd, er);
      check("t2_rd", rd, 64'h11223344BBBBBBBB);
      // zero strobe write leaves memory unchanged
      xact(1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, rd, er);
      check("wstrb0_err", er, 0);
      // 3: response held for 3 cycles
      xact(0, 64'h10, 64'h0, 8'h00, 3, rd, er);
      check("t3_rd", rd, 64'h11223344BBBBBBBB);
      // 4: misaligned write rejected
      xact(1, 64'h13, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, rd, er);
      check("t4_err", er, 1);
      check("t4_rdata", rd, 0);
      xact(0, 64'h10, 64'h0, 8'h00, 0, rd, er);
      check("t4_rd", rd, 64'h11223344BBBBBBBB);
      check("t4_rd_err", er, 0);
      xact(0, 64'h11, 64'h0, 8'h00, 0, rd, er);
      check("mis_rd_err", er, 1);
      check("mis_rd_rdata", rd, 0);
      // 5: address wrap
      xact(1, 64'h0, 64'hDEAD, 8'hFF, 0, rd, er);
      xact(0, 64'h800, 64'h0, 8'h00, 0, rd, er);
      check("t5_wrap", rd, 64'hDEAD);
      // 6: reset during BUSY drops the write
      xact(1, 64'h20, 64'h5555, 8'hFF, 0, rd, er);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h9999; req_wstrb = 8'hFF;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("t6_req_ready", req_ready, 1);
      check("t6_rsp_valid", rsp_valid, 0);
      check("t6_stall", stall, 0);
      check("t6_err", rsp_err, 0);
      check("t6_rdata", rsp_rdata, 0);
      repeat (6) @(posedge clk);
      #1 check("t6_no_rsp", rsp_valid, 0);
      xact(0, 64'h20, 64'h0, 8'h00, 0, rd, er);
      check("t6_rd", rd, 64'h5555);
`ifdef MEM_RAND_LAT_EN
      // 7: random latency covers both extremes
      begin
         logic saw4, saw7;
         saw4 = 1'b0; saw7 = 1'b0;
         for (int n = 0; n < 100; n++) begin
            xact(0, 64'h10, 64'h0, 8'h00, 0, rd, er);
            saw4 |= lat_last == 4;
            saw7 |= lat_last == 7;
         end
         check("t7_saw4", saw4, 1);
         check("t7_saw7", saw7, 1);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
